// File: rtl/s3_pkg.sv
// Shared definitions for the S3 context-retention subsystem.
// Holds the power FSM state type, datapath width defaults and the delay
// counter width, so the sequencer, its counter and the RAM agree on them.
package s3_pkg;

    localparam int unsigned DATA_W_DEFAULT = 4;
    localparam int unsigned OP_W_DEFAULT   = 2;
    localparam int unsigned CNT_W          = 4;

    // Encodings are visible on power_state, so the values are fixed.
    typedef enum logic [2:0] {
        StActive  = 3'd0,
        StSave    = 3'd1,
        StEntry   = 3'd2,
        StS3      = 3'd3,
        StWake    = 3'd4,
        StRestore = 3'd5,
        StCapture = 3'd6
    } power_state_e;

    // A settle delay must fit the 4-bit counter and last at least one cycle.
    function automatic bit delay_legal(input int unsigned delay);
        return (delay >= 1) && (delay <= 15);
    endfunction

endpackage

// File: rtl/s3_power_sequencer_if.sv
// Bus between the power sequencer (master) and the S3 retention RAM (slave).
// Ports:
//   ram_we / ram_s3        : write strobe and store(1)/retrieve(0) select
//   ram_*_wr               : context driven into the RAM on store
//   ram_result .. ram_operation : context returned by the RAM on retrieve
interface s3_power_sequencer_if
    import s3_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned OP_W   = OP_W_DEFAULT
);

    logic              ram_we;
    logic              ram_s3;
    logic [DATA_W-1:0] ram_result_wr;
    logic [DATA_W-1:0] ram_a_wr;
    logic [DATA_W-1:0] ram_b_wr;
    logic [OP_W-1:0]   ram_op_wr;
    logic [DATA_W-1:0] ram_result;
    logic [DATA_W-1:0] ram_operand_a;
    logic [DATA_W-1:0] ram_operand_b;
    logic [OP_W-1:0]   ram_operation;

    modport master (
        output ram_we, ram_s3, ram_result_wr, ram_a_wr, ram_b_wr, ram_op_wr,
        input  ram_result, ram_operand_a, ram_operand_b, ram_operation
    );

    modport slave (
        input  ram_we, ram_s3, ram_result_wr, ram_a_wr, ram_b_wr, ram_op_wr,
        output ram_result, ram_operand_a, ram_operand_b, ram_operation
    );

endinterface

// File: rtl/s3_delay_counter.sv
// Settle-delay down-counter shared by the S3 entry and wake phases.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset (count -> 0)
//   load         : load load_val this edge (has priority over counting)
//   load_val     : value loaded, i.e. delay - 1
//   enable       : decrement while non-zero
//   done         : count is zero
module s3_delay_counter
    import s3_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             enable,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/s3_power_sequencer.sv
// S3 power sequencer: saves live ALU context into the retention RAM on sleep
// entry, gates the ALU clock while resident, and restores the context on wake.
// Ports:
//   clk, reset_n           : clock, synchronous active-low reset
//   sleep_req, wake_req    : sampled power requests
//   alu_result .. operation: live ALU context to save
//   ram                    : retention RAM bus (master side)
//   alu_clk_en             : ALU clock enable
//   sleep_ack              : level, resident in S3
//   wake_ack               : one-cycle pulse, context restored and ALU resumed
//   ctx_valid, ctx_*       : restored context for the ALU
//   power_state            : FSM state encoding for debug
module s3_power_sequencer
    import s3_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEFAULT,
    parameter int unsigned OP_W        = OP_W_DEFAULT,
    parameter int unsigned ENTRY_DELAY = 4,
    parameter int unsigned WAKE_DELAY  = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sleep_req,
    input  logic                 wake_req,
    input  logic [DATA_W-1:0]    alu_result,
    input  logic [DATA_W-1:0]    operand_a,
    input  logic [DATA_W-1:0]    operand_b,
    input  logic [OP_W-1:0]      operation,
    s3_power_sequencer_if.master ram,
    output logic                 alu_clk_en,
    output logic                 sleep_ack,
    output logic                 wake_ack,
    output logic                 ctx_valid,
    output logic [DATA_W-1:0]    ctx_result,
    output logic [DATA_W-1:0]    ctx_a,
    output logic [DATA_W-1:0]    ctx_b,
    output logic [OP_W-1:0]      ctx_op,
    output logic [2:0]           power_state
);

    if (!delay_legal(ENTRY_DELAY)) begin : g_bad_entry_delay
        $error("ENTRY_DELAY must be in 1..15");
    end
    if (!delay_legal(WAKE_DELAY)) begin : g_bad_wake_delay
        $error("WAKE_DELAY must be in 1..15");
    end

    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_DELAY - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_DELAY - 1);

    power_state_e      state_q, state_d;
    logic              wake_pending_q, wake_pending_d;
    logic              wake_ack_q, wake_ack_d;
    logic              ctx_valid_q, ctx_valid_d;
    logic [DATA_W-1:0] ctx_result_q, ctx_result_d;
    logic [DATA_W-1:0] ctx_a_q, ctx_a_d;
    logic [DATA_W-1:0] ctx_b_q, ctx_b_d;
    logic [OP_W-1:0]   ctx_op_q, ctx_op_d;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_enable;
    logic              cnt_done;

    s3_delay_counter u_delay_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .enable   (cnt_enable),
        .done     (cnt_done)
    );

    assign cnt_enable = (state_q == StEntry) || (state_q == StWake);

    always_comb begin
        state_d        = state_q;
        wake_pending_d = wake_pending_q;
        cnt_load       = 1'b0;
        cnt_load_val   = ENTRY_LOAD;
        wake_ack_d     = (state_q == StCapture);
        ctx_valid_d    = ctx_valid_q;
        ctx_result_d   = ctx_result_q;
        ctx_a_d        = ctx_a_q;
        ctx_b_d        = ctx_b_q;
        ctx_op_d       = ctx_op_q;

        case (state_q)
            StActive: begin
                // Sleep wins over a simultaneous wake; wake is ignored here.
                if (sleep_req) begin
                    state_d     = StSave;
                    ctx_valid_d = 1'b0;
                end
            end
            StSave: begin
                if (wake_req) wake_pending_d = 1'b1;
                state_d      = StEntry;
                cnt_load     = 1'b1;
                cnt_load_val = ENTRY_LOAD;
            end
            StEntry: begin
                if (wake_req) wake_pending_d = 1'b1;
                if (cnt_done) state_d = StS3;
            end
            StS3: begin
                // An early wake still costs exactly one resident cycle.
                if (wake_req || wake_pending_q) begin
                    state_d        = StWake;
                    wake_pending_d = 1'b0;
                    cnt_load       = 1'b1;
                    cnt_load_val   = WAKE_LOAD;
                end
            end
            StWake: begin
                if (cnt_done) state_d = StRestore;
            end
            StRestore: begin
                state_d = StCapture;
            end
            StCapture: begin
                // RAM outputs were registered at the end of RESTORE.
                state_d      = StActive;
                ctx_valid_d  = 1'b1;
                ctx_result_d = ram.ram_result;
                ctx_a_d      = ram.ram_operand_a;
                ctx_b_d      = ram.ram_operand_b;
                ctx_op_d     = ram.ram_operation;
            end
            default: begin
                state_d = StActive;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= StActive;
            wake_pending_q <= 1'b0;
            wake_ack_q     <= 1'b0;
            ctx_valid_q    <= 1'b0;
            ctx_result_q   <= '0;
            ctx_a_q        <= '0;
            ctx_b_q        <= '0;
            ctx_op_q       <= '0;
        end else begin
            state_q        <= state_d;
            wake_pending_q <= wake_pending_d;
            wake_ack_q     <= wake_ack_d;
            ctx_valid_q    <= ctx_valid_d;
            ctx_result_q   <= ctx_result_d;
            ctx_a_q        <= ctx_a_d;
            ctx_b_q        <= ctx_b_d;
            ctx_op_q       <= ctx_op_d;
        end
    end

    // Strobes decode from the registered state only.
    always_comb begin
        ram.ram_we  = (state_q == StSave) || (state_q == StRestore);
        ram.ram_s3  = (state_q == StSave) || (state_q == StEntry) || (state_q == StS3);
        alu_clk_en  = (state_q == StActive) || (state_q == StSave);
        sleep_ack   = (state_q == StS3);
    end

    // Live context goes straight to the RAM so it is captured at the end of SAVE.
    assign ram.ram_result_wr = alu_result;
    assign ram.ram_a_wr      = operand_a;
    assign ram.ram_b_wr      = operand_b;
    assign ram.ram_op_wr     = operation;

    assign wake_ack    = wake_ack_q;
    assign ctx_valid   = ctx_valid_q;
    assign ctx_result  = ctx_result_q;
    assign ctx_a       = ctx_a_q;
    assign ctx_b       = ctx_b_q;
    assign ctx_op      = ctx_op_q;
    assign power_state = state_q;

endmodule

// File: tb/tb_s3_power_sequencer.sv
module tb_s3_power_sequencer;

    localparam int DATA_W      = 4;
    localparam int OP_W        = 2;
    localparam int ENTRY_DELAY = 4;
    localparam int WAKE_DELAY  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, sleep_req, wake_req;
    logic [3:0]  alu_result, operand_a, operand_b;
    logic [1:0]  operation;
    logic        alu_clk_en, sleep_ack, wake_ack, ctx_valid;
    logic [3:0]  ctx_result, ctx_a, ctx_b;
    logic [1:0]  ctx_op;
    logic [2:0]  power_state;

    s3_power_sequencer_if #(.DATA_W(DATA_W), .OP_W(OP_W)) ram_bus ();

    s3_power_sequencer #(
        .DATA_W      (DATA_W),
        .OP_W        (OP_W),
        .ENTRY_DELAY (ENTRY_DELAY),
        .WAKE_DELAY  (WAKE_DELAY)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sleep_req   (sleep_req),
        .wake_req    (wake_req),
        .alu_result  (alu_result),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .operation   (operation),
        .ram         (ram_bus),
        .alu_clk_en  (alu_clk_en),
        .sleep_ack   (sleep_ack),
        .wake_ack    (wake_ack),
        .ctx_valid   (ctx_valid),
        .ctx_result  (ctx_result),
        .ctx_a       (ctx_a),
        .ctx_b       (ctx_b),
        .ctx_op      (ctx_op),
        .power_state (power_state)
    );

    // Behavioural retention RAM: store on we&s3, register outputs on we&!s3.
    logic [13:0] ram_store = '0;
    logic [13:0] ram_out   = '0;
    always @(posedge clk) begin
        if (ram_bus.ram_we && ram_bus.ram_s3)
            ram_store <= {ram_bus.ram_result_wr, ram_bus.ram_a_wr, ram_bus.ram_b_wr,
                          ram_bus.ram_op_wr};
        else if (ram_bus.ram_we && !ram_bus.ram_s3)
            ram_out <= ram_store;
    end
    assign {ram_bus.ram_result, ram_bus.ram_operand_a, ram_bus.ram_operand_b,
            ram_bus.ram_operation} = ram_out;

    // Reference model: timeline of one sleep/wake transaction.
    // k = number of clock edges seen; s = edge sampling sleep (SAVE follows),
    // w = edge sampling the effective wake (WAKE follows).
    int          k;
    int          s;
    int          w;
    int          n_checks;
    int          n_fail;
    bit          valid_exp;
    logic [13:0] ctx_exp;
    logic [13:0] live;
    logic [13:0] saved;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got 0x%0h, expected 0x%0h", tag, k, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        #1;
    endtask

    task automatic drive_live(input logic [13:0] v);
        {alu_result, operand_a, operand_b, operation} = v;
    endtask

    // Phase number of the cycle following edge kk, from the latency rules.
    function automatic int phase_of(input int kk);
        if (kk == s) return 1;
        if (kk <= s + ENTRY_DELAY) return 2;
        if (kk < w) return 3;
        if (kk < w + WAKE_DELAY) return 4;
        if (kk == w + WAKE_DELAY) return 5;
        if (kk == w + WAKE_DELAY + 1) return 6;
        return 0;
    endfunction

    task automatic check_outputs(input int ph, input bit wack);
        logic [5:0] exp_flags;
        logic [2:0] exp_state;
        exp_flags = {(ph == 1) || (ph == 5), (ph >= 1) && (ph <= 3), ph <= 1, ph == 3,
                     wack, valid_exp};
        exp_state = 3'(ph);
        check_eq("flags{we,s3,clk_en,sleep_ack,wake_ack,ctx_valid}",
                 32'({ram_bus.ram_we, ram_bus.ram_s3, alu_clk_en, sleep_ack, wake_ack,
                      ctx_valid}), 32'(exp_flags));
        check_eq("power_state", 32'(power_state), 32'(exp_state));
        check_eq("ctx", 32'({ctx_result, ctx_a, ctx_b, ctx_op}), 32'(ctx_exp));
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        sleep_req = 1'($urandom_range(0, 1));
        wake_req  = 1'($urandom_range(0, 1));
        tick();
        tick();
        valid_exp = 1'b0;
        ctx_exp   = '0;
        check_outputs(0, 1'b0);
        reset_n   = 1'b1;
        sleep_req = 1'b0;
        wake_req  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check_outputs(0, 1'b0);
        end
    endtask

    // One sleep/wake round trip. early: wake raised during SAVE/ENTRY;
    // both: wake high on the sleep edge; noise: random sleep_req while asleep;
    // abort_off > 0: reset during WAKE.
    task automatic run_txn(input bit early, input bit both, input bit noise,
                           input int abort_off, input logic [13:0] ctx_val);
        int  gap;
        int  early_k;
        int  ph;
        bit  wack;
        gap = int'($urandom_range(1, 4));
        for (int i = 0; i < gap; i++) begin
            sleep_req = 1'b0;
            wake_req  = 1'($urandom_range(0, 1));
            tick();
            check_outputs(0, 1'b0);
        end
        live = ctx_val;
        drive_live(live);
        saved     = live;
        sleep_req = 1'b1;
        wake_req  = both;
        tick();
        s         = k;
        sleep_req = 1'b0;
        wake_req  = 1'b0;
        early_k   = s + int'($urandom_range(0, ENTRY_DELAY));
        if (early) w = s + ENTRY_DELAY + 2;
        else       w = s + ENTRY_DELAY + 2 + int'($urandom_range(0, 3));
        forever begin
            ph   = phase_of(k);
            wack = (k == w + WAKE_DELAY + 2);
            if (k == s) begin
                valid_exp = 1'b0;
                check_eq("ram_wr", 32'({ram_bus.ram_result_wr, ram_bus.ram_a_wr,
                                        ram_bus.ram_b_wr, ram_bus.ram_op_wr}), 32'(saved));
            end
            if (wack) begin
                valid_exp = 1'b1;
                ctx_exp   = saved;
            end
            check_outputs(ph, wack);
            if (wack) break;
            if ((abort_off > 0) && (k == w + abort_off - 1)) begin
                do_reset();
                return;
            end
            if (k > s) begin
                live = 14'($urandom);
                drive_live(live);
            end
            wake_req  = early ? (k == early_k) : (k == w - 1);
            sleep_req = (noise && (k < w + WAKE_DELAY)) ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
        end
        sleep_req = 1'b0;
        wake_req  = 1'b0;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        k         = 0;
        s         = -100;
        w         = -100;
        valid_exp = 1'b0;
        ctx_exp   = '0;
        reset_n   = 1'b0;
        sleep_req = 1'b0;
        wake_req  = 1'b0;
        live      = 14'($urandom);
        drive_live(live);
        tick();
        tick();
        check_outputs(0, 1'b0);
        reset_n = 1'b1;

        run_txn(1'b0, 1'b0, 1'b0, 0, {4'hA, 4'h3, 4'h7, 2'b01});
        run_txn(1'b1, 1'b0, 1'b0, 0, 14'($urandom));
        run_txn(1'b0, 1'b1, 1'b1, 0, 14'($urandom));
        run_txn(1'b0, 1'b0, 1'b0, 3, 14'($urandom));
        run_txn(1'b0, 1'b0, 1'b0, 0, 14'($urandom));

        for (int i = 0; i < 30; i++) begin
            run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, WAKE_DELAY - 1)) : 0,
                    14'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s3_power_sequencer.md
Name: s3_power_sequencer

Overview:
Initiator-side controller for the S3 context retention RAM. It drives the RAM's write-enable and s3_state strobes to save live ALU context on sleep entry, and to read it back on wake. It gates the ALU clock enable and captures the restored context for the ALU. Sits between the system power-request logic and the ALU/RAM pair.

Parameters:
DATA_W, 4, width of ALU result and operands
OP_W, 2, width of ALU opcode
ENTRY_DELAY, 4, settle cycles between context save and S3 residency (legal 1..15)
WAKE_DELAY, 8, power-up settle cycles before context restore (legal 1..15)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous, active-low reset
sleep_req  in  1  request S3 entry, sampled level
wake_req  in  1  request S3 exit, sampled level
alu_result  in  DATA_W  live ALU result to save
operand_a  in  DATA_W  live operand A to save
operand_b  in  DATA_W  live operand B to save
operation  in  OP_W  live opcode to save
ram_result  in  DATA_W  retention RAM retrieved result
ram_operand_a  in  DATA_W  retention RAM retrieved operand A
ram_operand_b  in  DATA_W  retention RAM retrieved operand B
ram_operation  in  OP_W  retention RAM retrieved opcode
ram_we  out  1  retention RAM write_enable
ram_s3  out  1  retention RAM s3_state (1 = store, 0 = retrieve)
ram_result_wr, ram_a_wr, ram_b_wr, ram_op_wr  out  DATA_W/DATA_W/DATA_W/OP_W  context driven to RAM data inputs
alu_clk_en  out  1  ALU clock enable
sleep_ack  out  1  level: block is resident in S3
wake_ack  out  1  one-cycle pulse: context restored, ALU resumed
ctx_valid  out  1  restored context registers are valid
ctx_result, ctx_a, ctx_b, ctx_op  out  DATA_W/DATA_W/DATA_W/OP_W  restored context
power_state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset: a clock edge with reset_n=0 forces the state to ACTIVE, the counter to 0 and wake_pending to 0. Outputs after reset: alu_clk_en=1; ram_we=0, ram_s3=0, sleep_ack=0, wake_ack=0, ctx_valid=0, ctx_* = 0. Reset applies in any state, including mid-save or mid-restore. This block never clears RAM contents.
- States: ACTIVE(0), SAVE(1), ENTRY(2), S3(3), WAKE(4), RESTORE(5), CAPTURE(6). All outputs are registered or decoded from the registered state only.
- ACTIVE: alu_clk_en=1. If sleep_req=1 at an edge, go to SAVE and clear ctx_valid. wake_req is ignored in ACTIVE, including when it arrives together with sleep_req (sleep wins).
- SAVE (1 cycle): ram_we=1, ram_s3=1. ram_*_wr carry the live inputs combinationally, so the RAM captures the context at the end of this cycle. alu_clk_en stays 1 this cycle.
- ENTRY (ENTRY_DELAY cycles): alu_clk_en=0, ram_s3=1, ram_we=0. The counter loads ENTRY_DELAY-1 on entry and counts down; at 0 go to S3.
- S3: sleep_ack=1, ram_s3=1, alu_clk_en=0. If wake_req=1 or wake_pending=1, go to WAKE and clear wake_pending.
- wake_req=1 during SAVE or ENTRY sets wake_pending. The block still completes the full entry and spends exactly one cycle in S3 with sleep_ack=1 before waking.
- sleep_req during any non-ACTIVE state is ignored.
- WAKE (WAKE_DELAY cycles): ram_s3=0, ram_we=0, alu_clk_en=0. Counter behaves as in ENTRY; at 0 go to RESTORE.
- RESTORE (1 cycle): ram_we=1, ram_s3=0. The RAM registers its outputs at the end of this cycle.
- CAPTURE (1 cycle): ram_* inputs are valid. ctx_* load from ram_* at the end of the cycle, ctx_valid is set, and the state goes to ACTIVE.
- wake_ack pulses high for the first ACTIVE cycle after CAPTURE. alu_clk_en=1 from that cycle.
- Latency: sleep_req sampled at edge t → SAVE in cycle t+1 → sleep_ack high from cycle t+2+ENTRY_DELAY.
- Latency: wake_req sampled at edge w → wake_ack in cycle w+3+WAKE_DELAY.
- Counter is 4 bits. Out-of-range delays fail an elaboration-time check.

Decomposition:
- Shared package s3_pkg holds the state enum (7 states, 3-bit) and the DATA_W/OP_W defaults, for reuse by the RAM and the top level.
- One natural sub-module: s3_delay_counter (load value, count-down, done flag), instantiated once and shared by ENTRY and WAKE.

Test Plan:
- Reset with reset_n=0 held 2 cycles in any state → state ACTIVE, alu_clk_en=1, ctx_valid=0, all ctx_*=0.
- Live context result=4'hA, a=4'h3, b=4'h7, op=2'b01; pulse sleep_req at edge 0 → ram_we=1 and ram_s3=1 in cycle 1 only; sleep_ack=1 from cycle 6 (ENTRY_DELAY=4).
- From S3, change live inputs to 0, then pulse wake_req → wake_ack in cycle w+11 (WAKE_DELAY=8) with ctx=A/3/7/01, ctx_valid=1, alu_clk_en=1.
- wake_req raised during ENTRY → exactly one S3 cycle with sleep_ack=1, then WAKE; wake_pending cleared.
- sleep_req and wake_req high on the same edge in ACTIVE → SAVE taken, wake ignored. sleep_req held high during WAKE → no effect.
- reset_n=0 during WAKE, released → ACTIVE, no ram_we pulse issued, ctx_valid=0.
